mem_access_unit: RTL and testbench

Memory-stage load/store unit that consumes the decode controls (`mem_write`, `wb_load`, `mem_load_type`, `mem_store_type`) after they travel through the execute stage. It turns each load or store into a single word-aligned data-memory transaction with byte enables, and runs a request/grant/response handshake FSM. Load data is aligned and sign/zero-extended before write-back. The unit stalls the pipeline while a transaction is outstanding and flags misaligned accesses without touching memory.

---
 rtl/mem_access_unit.sv | 219 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage load/store unit. Converts one load or store from the execute
// stage into a single word-aligned data-memory transaction with byte enables,
// drives a request/grant/response handshake, and aligns and extends load data
// for write-back. Misaligned accesses are flagged and never reach memory.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   in_valid / in_ready      operation handshake from execute
//   mem_write, wb_load       store / load controls (store wins if both set)
//   mem_load_type            LB=000 LH=001 LW=010 LBU=011 LHU=100 DEF=111
//   mem_store_type           SB=00 SH=01 SW=10 DEF=11 (DEF writes nothing)
//   addr, store_data         effective byte address and rs2 value
//   dmem_*                   data-memory request/grant/response channel
//   stall                    hold the pipeline
//   done                     one-cycle completion pulse
//   load_data                extended load result, held until the next load
//   misaligned               one-cycle pulse, access dropped
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_write,
  input  logic              wb_load,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misaligned
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          ltype_q, ltype_d;
  logic                done_q, done_d;
  logic                mis_q, mis_d;
  logic [31:0]         load_data_q, load_data_d;

  logic        accept;
  logic        misalign_in;
  logic        store_def;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign accept    = in_valid & in_ready & (mem_write | wb_load);
  assign store_def = mem_write & (mem_store_type == 2'b11);

  // Alignment check on the incoming operation; mem_write takes priority.
  always_comb begin
    misalign_in = 1'b0;
    if (mem_write) begin
      case (mem_store_type)
        2'b01:   misalign_in = addr[0];
        2'b10:   misalign_in = |addr[1:0];
        default: misalign_in = 1'b0;
      endcase
    end else begin
      case (mem_load_type)
        3'b000, 3'b011: misalign_in = 1'b0;
        3'b001, 3'b100: misalign_in = addr[0];
        default:        misalign_in = |addr[1:0];  // LW, DEF and unused codes
      endcase
    end
  end

  // Store lane placement: data is replicated so the enabled lanes carry it.
  always_comb begin
    be_in    = 4'b0000;
    wdata_in = store_data;
    case (mem_store_type)
      2'b00: begin
        be_in    = 4'b0001 << addr[1:0];
        wdata_in = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_in    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{store_data[15:0]}};
      end
      2'b10:   be_in = 4'b1111;
      default: be_in = 4'b0000;
    endcase
  end

  // Load extraction uses the offset latched at accept time.
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ltype_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b011:  load_ext = {24'h0, byte_sel};
      3'b100:  load_ext = {16'h0, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0;
      off_q       <= 2'b00;
      ltype_q     <= 3'b000;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      off_q       <= off_d;
      ltype_q     <= ltype_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
      load_data_q <= load_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !misalign_in && !store_def) state_d = REQ;
      REQ:  if (dmem_gnt) state_d = we_q ? IDLE : RESP;
      RESP: if (dmem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; request fields only change when a request is
  // about to be issued, so they stay constant across the whole REQ phase.
  always_comb begin
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    off_d       = off_q;
    ltype_d     = ltype_q;
    done_d      = 1'b0;
    mis_d       = 1'b0;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          off_d   = addr[1:0];
          ltype_d = mem_load_type;
          if (misalign_in) begin
            mis_d = 1'b1;
          end else if (store_def) begin
            done_d = 1'b1;
          end else begin
            we_d    = mem_write;
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            be_d    = mem_write ? be_in : 4'b1111;
            wdata_d = mem_write ? wdata_in : 32'h0;
          end
        end
      end
      REQ: begin
        if (dmem_gnt && we_q) done_d = 1'b1;
      end
      RESP: begin
        if (dmem_rvalid) begin
          done_d      = 1'b1;
          load_data_d = load_ext;
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready   = (state_q == IDLE);
    dmem_req   = (state_q == REQ);
    dmem_we    = we_q;
    dmem_addr  = addr_q;
    dmem_be    = be_q;
    dmem_wdata = wdata_q;
    done       = done_q;
    misaligned = mis_q;
    load_data  = load_data_q;
    stall      = (in_valid & (mem_write | wb_load) & in_ready) | ~in_ready;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        mem_write;
  logic        wb_load;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_store_type;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;

  int tests_run;
  int tests_failed;
  logic [31:0] last_load;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_write(mem_write), .wb_load(wb_load),
    .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
    .addr(addr), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall(stall), .done(done), .load_data(load_data), .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    in_valid = 0; mem_write = 0; wb_load = 0;
    mem_load_type = 3'b000; mem_store_type = 2'b00;
    addr = 32'h0; store_data = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
    tests_run++; if (dmem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b expected 0", dmem_we); end
    tests_run++; if (dmem_be !== 4'h0) begin tests_failed++; $display("FAIL reset_be: got %h expected 0", dmem_be); end
    tests_run++; if (dmem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", dmem_addr); end
    tests_run++; if (dmem_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_wdata: got %h expected 0", dmem_wdata); end
    tests_run++; if (load_data !== 32'h0) begin tests_failed++; $display("FAIL reset_load_data: got %h expected 0", load_data); end
    tests_run++; if (done !== 1'b0 || misaligned !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: got done=%b mis=%b expected 0 0", done, misaligned); end
    @(posedge clk); #1 rst = 0;
    $display("[TB] reset checked");
  endtask

  task automatic do_store(input string name, input logic [1:0] st, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    @(posedge clk); #1;
    in_valid = 1; mem_write = 1; wb_load = 0; mem_store_type = st; addr = a; store_data = d;
    @(negedge clk);
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL %s_stall: got %b expected 1", name, stall); end
    @(posedge clk); #1;
    idle_inputs(); dmem_gnt = 1;
    @(negedge clk);
    tests_run++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin tests_failed++; $display("FAIL %s_req: got req=%b we=%b expected 1 1", name, dmem_req, dmem_we); end
    tests_run++; if (dmem_addr !== exp_addr) begin tests_failed++; $display("FAIL %s_addr: got %h expected %h", name, dmem_addr, exp_addr); end
    tests_run++; if (dmem_be !== exp_be) begin tests_failed++; $display("FAIL %s_be: got %b expected %b", name, dmem_be, exp_be); end
    tests_run++; if (dmem_wdata !== exp_wdata) begin tests_failed++; $display("FAIL %s_wdata: got %h expected %h", name, dmem_wdata, exp_wdata); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL %s_early_done: got %b expected 0", name, done); end
    @(posedge clk); #1 dmem_gnt = 0;
    @(negedge clk);
    tests_run++; if (done !== 1'b1 || dmem_req !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL %s_done: got done=%b req=%b rdy=%b expected 1 0 1", name, done, dmem_req, in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL %s_done_width: got %b expected 0", name, done); end
    $display("[TB] store %s addr=%h data=%h be=%b wdata=%h", name, a, d, dmem_be, dmem_wdata);
  endtask

  task automatic do_load(input string name, input logic [2:0] lt, input logic [31:0] a,
                         input logic [31:0] exp_addr, input logic [31:0] rd, input logic [31:0] exp,
                         input int gnt_dly, input int rv_dly, input logic intrude);
    @(posedge clk); #1;
    in_valid = 1; wb_load = 1; mem_write = 0; mem_load_type = lt; addr = a;
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 0; i < gnt_dly; i++) begin
      if (intrude) begin
        in_valid = 1; mem_write = 1; mem_store_type = 2'b10; addr = 32'h0000_0444; store_data = 32'h5555_AAAA;
      end
      dmem_gnt = 0;
      @(negedge clk);
      tests_run++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 4'hF || dmem_addr !== exp_addr) begin
        tests_failed++; $display("FAIL %s_hold%0d: got req=%b we=%b be=%b addr=%h expected 1 0 1111 %h", name, i, dmem_req, dmem_we, dmem_be, dmem_addr, exp_addr); end
      tests_run++; if (stall !== 1'b1 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL %s_stall%0d: got stall=%b rdy=%b expected 1 0", name, i, stall, in_ready); end
      @(posedge clk); #1;
    end
    idle_inputs(); dmem_gnt = 1;
    @(negedge clk);
    tests_run++; if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_we !== 1'b0) begin tests_failed++; $display("FAIL %s_req: got req=%b addr=%h we=%b expected 1 %h 0", name, dmem_req, dmem_addr, dmem_we, exp_addr); end
    @(posedge clk); #1 dmem_gnt = 0;
    for (int j = 0; j < rv_dly; j++) begin
      @(negedge clk);
      tests_run++; if (dmem_req !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL %s_resp_wait%0d: got req=%b stall=%b done=%b expected 0 1 0", name, j, dmem_req, stall, done); end
      @(posedge clk); #1;
    end
    dmem_rvalid = 1; dmem_rdata = rd;
    @(negedge clk);
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL %s_early_done: got %b expected 0", name, done); end
    @(posedge clk); #1;
    dmem_rvalid = 0; dmem_rdata = 32'h0;
    @(negedge clk);
    tests_run++; if (done !== 1'b1 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL %s_done: got done=%b rdy=%b expected 1 1", name, done, in_ready); end
    tests_run++; if (load_data !== exp) begin tests_failed++; $display("FAIL %s_data: got %h expected %h", name, load_data, exp); end
    last_load = exp;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (done !== 1'b0 || load_data !== exp) begin tests_failed++; $display("FAIL %s_hold_data: got done=%b data=%h expected 0 %h", name, done, load_data, exp); end
    $display("[TB] load %s addr=%h rdata=%h load_data=%h", name, a, rd, load_data);
  endtask

  task automatic do_drop(input string name, input logic mw, input logic [2:0] lt,
                         input logic [1:0] st, input logic [31:0] a,
                         input logic exp_mis, input logic exp_done);
    @(posedge clk); #1;
    in_valid = 1; mem_write = mw; wb_load = ~mw; mem_load_type = lt; mem_store_type = st; addr = a; store_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    tests_run++; if (misaligned !== exp_mis || done !== exp_done) begin tests_failed++; $display("FAIL %s_pulse: got mis=%b done=%b expected %b %b", name, misaligned, done, exp_mis, exp_done); end
    tests_run++; if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL %s_noreq: got req=%b rdy=%b expected 0 1", name, dmem_req, in_ready); end
    tests_run++; if (load_data !== last_load) begin tests_failed++; $display("FAIL %s_load_hold: got %h expected %h", name, load_data, last_load); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (misaligned !== 1'b0 || done !== 1'b0 || dmem_req !== 1'b0) begin tests_failed++; $display("FAIL %s_after: got mis=%b done=%b req=%b expected 0 0 0", name, misaligned, done, dmem_req); end
    $display("[TB] dropped %s addr=%h mis=%b done=%b", name, a, exp_mis, exp_done);
  endtask

  task automatic test_stores();
    do_store("sw",  2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    do_store("sb",  2'b00, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
    do_store("sh",  2'b01, 32'h0000_0102, 32'h0000_1234, 32'h0000_0100, 4'b1100, 32'h1234_1234);
    do_store("sb1", 2'b00, 32'h0000_0101, 32'h0000_0077, 32'h0000_0100, 4'b0010, 32'h7777_7777);
  endtask

  task automatic test_loads();
    do_load("lb0",  3'b000, 32'h0000_0200, 32'h0000_0200, 32'h80F0_7F01, 32'h0000_0001, 0, 0, 1'b0);
    do_load("lb3",  3'b000, 32'h0000_0203, 32'h0000_0200, 32'h80F0_7F01, 32'hFFFF_FF80, 0, 0, 1'b0);
    do_load("lbu3", 3'b011, 32'h0000_0203, 32'h0000_0200, 32'h80F0_7F01, 32'h0000_0080, 0, 0, 1'b0);
    do_load("lh2",  3'b001, 32'h0000_0202, 32'h0000_0200, 32'h80F0_7F01, 32'hFFFF_80F0, 0, 0, 1'b0);
    do_load("lhu2", 3'b100, 32'h0000_0202, 32'h0000_0200, 32'h80F0_7F01, 32'h0000_80F0, 0, 0, 1'b0);
    do_load("lw",   3'b010, 32'h0000_0200, 32'h0000_0200, 32'h80F0_7F01, 32'h80F0_7F01, 0, 0, 1'b0);
    do_load("ldef", 3'b111, 32'h0000_0200, 32'h0000_0200, 32'h80F0_7F01, 32'h80F0_7F01, 0, 0, 1'b0);
  endtask

  task automatic test_misaligned();
    do_drop("lw_mis",  1'b0, 3'b010, 2'b00, 32'h0000_0201, 1'b1, 1'b0);
    do_drop("sh_mis",  1'b1, 3'b000, 2'b01, 32'h0000_0101, 1'b1, 1'b0);
    do_drop("lh_mis",  1'b0, 3'b001, 2'b00, 32'h0000_0203, 1'b1, 1'b0);
    do_drop("sdef",    1'b1, 3'b000, 2'b11, 32'h0000_0100, 1'b0, 1'b1);
  endtask

  task automatic test_delayed();
    do_load("lw_slow", 3'b010, 32'h0000_0208, 32'h0000_0208, 32'h1357_9BDF, 32'h1357_9BDF, 3, 2, 1'b1);
  endtask

  task automatic test_reset_abort();
    @(posedge clk); #1;
    in_valid = 1; wb_load = 1; mem_load_type = 3'b010; addr = 32'h0000_0300;
    @(posedge clk); #1;
    idle_inputs(); dmem_gnt = 1;
    @(posedge clk); #1 dmem_gnt = 0;
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b0 || dmem_req !== 1'b0) begin tests_failed++; $display("FAIL abort_in_resp: got rdy=%b req=%b expected 0 0", in_ready, dmem_req); end
    #1 rst = 1;
    #1;
    tests_run++; if (in_ready !== 1'b1 || dmem_req !== 1'b0 || dmem_addr !== 32'h0 || dmem_be !== 4'h0 || load_data !== 32'h0) begin
      tests_failed++; $display("FAIL abort_reset_vals: got rdy=%b req=%b addr=%h be=%b data=%h expected 1 0 0 0 0", in_ready, dmem_req, dmem_addr, dmem_be, load_data); end
    @(posedge clk); #1 rst = 0;
    dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1 dmem_rvalid = 0; dmem_rdata = 32'h0;
    @(negedge clk);
    tests_run++; if (done !== 1'b0 || load_data !== 32'h0) begin tests_failed++; $display("FAIL abort_stale_rvalid: got done=%b data=%h expected 0 0", done, load_data); end
    last_load = 32'h0;
    $display("[TB] reset abort during RESP checked");
    do_load("lw_after_rst", 3'b010, 32'h0000_0304, 32'h0000_0304, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 0, 1, 1'b0);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; last_load = 32'h0;
    rst = 1; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 32'h0;
    idle_inputs();
    test_reset();
    test_stores();
    test_loads();
    test_misaligned();
    test_delayed();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
